// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; done N clocks after start (1 clock on divide-by-zero).
// No backpressure: start is ignored while busy or finishing; results hold until the next accepted start.
module seq_divider #(
    parameter int N      = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] count;
    logic [N-1:0]  acc;       // dividend bits leave at the top, quotient bits enter at the bottom
    logic [N:0]    rem;
    logic [N-1:0]  dsr_mag;
    logic [N-1:0]  dvd_raw;
    logic          neg_q;
    logic          neg_r;
    logic          zero_dsr;

    logic [N-1:0]  dvd_mag_in;
    logic [N-1:0]  dsr_mag_in;
    logic [N:0]    rem_sh;
    logic [N+1:0]  diff;
    logic          q_bit;
    logic [N:0]    rem_nxt;
    logic [N-1:0]  acc_nxt;
    logic          last;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;

    always_comb begin
        dvd_mag_in = (SIGNED && dividend[N-1]) ? -dividend : dividend;
        dsr_mag_in = (SIGNED && divisor[N-1])  ? -divisor  : divisor;

        // One extra guard bit keeps the trial-subtraction sign even for full-scale divisors.
        rem_sh  = {rem[N-1:0], acc[N-1]};
        diff    = {1'b0, rem_sh} - {2'b00, dsr_mag};
        q_bit   = ~diff[N+1];
        rem_nxt = q_bit ? diff[N:0] : rem_sh;
        acc_nxt = {acc[N-2:0], q_bit};
        last    = (count == CW'(N - 1));

        q_fix   = neg_q ? -acc_nxt : acc_nxt;
        r_fix   = neg_r ? -rem_nxt[N-1:0] : rem_nxt[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (zero_dsr || last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            rem         <= '0;
            dsr_mag     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_dsr    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count       <= '0;
                        acc         <= dvd_mag_in;
                        rem         <= '0;
                        dsr_mag     <= dsr_mag_in;
                        dvd_raw     <= dividend;
                        neg_q       <= SIGNED && (dividend[N-1] ^ divisor[N-1]);
                        neg_r       <= SIGNED && dividend[N-1];
                        zero_dsr    <= (divisor == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    if (zero_dsr) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        acc   <= acc_nxt;
                        rem   <= rem_nxt;
                        count <= CW'(count + 1'b1);
                        if (last) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: one unsigned and one signed instance, scoreboard queues checked on every done.
module tb_seq_divider;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;

    logic          start_u, start_s;
    logic [N-1:0]  dvd_u, dsr_u, dvd_s, dsr_s;
    logic [N-1:0]  q_u, r_u, q_s, r_s;
    logic          busy_u, done_u, dz_u;
    logic          busy_s, done_s, dz_s;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t exp_u[$];
    exp_t exp_s[$];

    int tests = 0;
    int fails = 0;
    int done_cnt_u = 0;
    int done_cnt_s = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .dividend(dvd_u), .divisor(dsr_u),
        .quotient(q_u), .remainder(r_u), .busy(busy_u), .done(done_u), .div_by_zero(dz_u)
    );

    seq_divider #(.N(N), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .dividend(dvd_s), .divisor(dsr_s),
        .quotient(q_s), .remainder(r_s), .busy(busy_s), .done(done_s), .div_by_zero(dz_s)
    );

    // Reference: plain language-level division, with the two special cases stated explicitly.
    function automatic exp_t model(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        e.a  = a;
        e.b  = b;
        e.dz = 1'b0;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
        end else begin
            sa  = a;
            sb  = b;
            e.q = sa / sb;
            e.r = sa % sb;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_out(input bit s, input logic [N-1:0] q, input logic [N-1:0] r, input bit dz);
        exp_t    e;
        longint  ar;
        longint  ab;
        if ((s ? exp_s.size() : exp_u.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with no pending op (signed=%0d)", s);
            return;
        end
        e = s ? exp_s.pop_front() : exp_u.pop_front();
        cmp(s ? "s_quotient" : "u_quotient", q, e.q);
        cmp(s ? "s_remainder" : "u_remainder", r, e.r);
        cmp(s ? "s_div_by_zero" : "u_div_by_zero", N'(dz), N'(e.dz));
        if (!e.dz) begin
            cmp("identity", q * e.b + r, e.a);
            if (s) begin
                ar = longint'($signed(r));
                ab = longint'($signed(e.b));
                if (ar < 0) ar = -ar;
                if (ab < 0) ab = -ab;
            end else begin
                ar = longint'(r);
                ab = longint'(e.b);
            end
            cmp("rem_bound", N'(ar < ab), N'(1));
        end
    endtask

    always @(negedge clk) begin
        if (done_u) begin
            done_cnt_u++;
            check_out(1'b0, q_u, r_u, dz_u);
        end
        if (done_s) begin
            done_cnt_s++;
            check_out(1'b1, q_s, r_s, dz_s);
        end
    end

    // Counts negedges after the accepting edge until done; 0 means done right after that edge.
    task automatic wait_done(input bit s, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (s ? done_s : done_u) seen = 1'b1;
            else cyc++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
        end
    endtask

    task automatic drive(input bit s, input bit st, input logic [N-1:0] a, input logic [N-1:0] b);
        if (s) begin
            start_s = st; dvd_s = a; dsr_s = b;
        end else begin
            start_u = st; dvd_u = a; dsr_u = b;
        end
    endtask

    task automatic issue(input bit s, input logic [N-1:0] a, input logic [N-1:0] b, input int exp_lat);
        int cyc;
        bit seen;
        if (s) exp_s.push_back(model(s, a, b));
        else   exp_u.push_back(model(s, a, b));
        @(negedge clk);
        drive(s, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(s, 1'b0, a, b);
        wait_done(s, cyc, seen);
        if (seen && exp_lat >= 0) begin
            cmp("latency", N'(cyc), N'(exp_lat));
            cmp("busy_in_done", N'(s ? busy_s : busy_u), N'(0));
        end
    endtask

    initial begin
        int         cyc;
        bit         seen;
        int         cnt_before;
        bit         s;
        logic [N-1:0] a;
        logic [N-1:0] b;

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        cmp("rst_quotient", q_u, '0);
        cmp("rst_remainder", r_u, '0);
        cmp("rst_flags", N'({busy_u, done_u, dz_u, busy_s, done_s, dz_s}), '0);
        rst = 1'b0;

        issue(1'b0, 100, 7, N);
        repeat (3) @(negedge clk);
        cmp("hold_quotient", q_u, 14);

        issue(1'b0, 12345, 0, 1);
        issue(1'b0, 50, 5, N);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N);
        issue(1'b0, 5, 32'hFFFF_FFFF, N);
        issue(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, N);

        issue(1'b1, -32'sd7, 32'sd2, N);
        issue(1'b1, 32'sd7, -32'sd2, N);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, N);
        issue(1'b1, -32'sd5, 0, 1);

        // A start pulse mid-operation with different operands must be ignored.
        exp_u.push_back(model(1'b0, 600, 7));
        @(negedge clk);
        drive(1'b0, 1'b1, 600, 7);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 600, 7);
        repeat (5) @(negedge clk);
        drive(1'b0, 1'b1, 99, 3);
        @(negedge clk);
        drive(1'b0, 1'b0, 99, 3);
        wait_done(1'b0, cyc, seen);
        repeat (N + 5) @(negedge clk);

        // Reset in the middle of an operation aborts it without a done pulse.
        cnt_before = done_cnt_u;
        @(negedge clk);
        drive(1'b0, 1'b1, 777, 3);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 777, 3);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("abort_quotient", q_u, '0);
        cmp("abort_remainder", r_u, '0);
        cmp("abort_flags", N'({busy_u, done_u, dz_u}), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N + 5) @(negedge clk);
        cmp("abort_no_done", N'(done_cnt_u), N'(cnt_before));
        issue(1'b0, 1000, 10, N);

        for (int i = 0; i < 20; i++) begin
            s = (i % 2) == 1;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 1000);
            if (b == 0) b = 1;
            if (s && $urandom_range(0, 1) == 1) b = -b;
            issue(s, a, b, N);
        end

        repeat (5) @(negedge clk);
        cmp("pending_u", N'(exp_u.size()), '0);
        cmp("pending_s", N'(exp_s.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
